// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: sequences fetch/decode/execute steps
// and decodes ALU control from aluop and funct.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic       pcen,
   output logic       instr_done,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic [2:0] aluc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_e;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_e     state_q, state_d;
   logic       pcwrite, branch, illegal;
   logic       mw_raw, irw_raw, rw_raw, done_raw;
   logic [1:0] aluop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = FETCH;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      illegal  = 1'b0;
      mw_raw   = 1'b0;
      irw_raw  = 1'b0;
      rw_raw   = 1'b0;
      done_raw = 1'b0;
      aluop    = 2'b00;
      iord     = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      case (state_q)
         FETCH: begin
            irw_raw = 1'b1;
            alusrcb = 2'b01;
            pcwrite = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYP:      state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
               default:      done_raw = 1'b1;
            endcase
         end
         MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (op == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            iord    = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            memtoreg = 1'b1;
            rw_raw   = 1'b1;
            done_raw = 1'b1;
         end
         MEMWR: begin
            iord     = 1'b1;
            mw_raw   = 1'b1;
            done_raw = 1'b1;
         end
         RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = RTYPEWB;
         end
         RTYPEWB: begin
            regdst   = 1'b1;
            rw_raw   = 1'b1;
            done_raw = 1'b1;
         end
         BEQEX: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsrc    = 2'b01;
            branch   = 1'b1;
            done_raw = 1'b1;
         end
         ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = ADDIWB;
         end
         ADDIWB: begin
            rw_raw   = 1'b1;
            done_raw = 1'b1;
         end
         JEX: begin
            pcsrc    = 2'b10;
            pcwrite  = 1'b1;
            done_raw = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      aluc = 3'b010;
      case (aluop)
         2'b00: aluc = 3'b010;
         2'b01: aluc = 3'b110;
         2'b10: begin
            case (funct)
               6'b100000: aluc = 3'b010;
               6'b100010: aluc = 3'b110;
               6'b100100: aluc = 3'b000;
               6'b100101: aluc = 3'b001;
               6'b101010: aluc = 3'b111;
               default:   aluc = 3'b011;
            endcase
         end
         default: aluc = 3'b011;
      endcase
      if (illegal) aluc = 3'b000;
   end

   // Write enables are held off while reset is asserted, even mid-instruction.
   assign memwrite   = mw_raw & ~rst;
   assign irwrite    = irw_raw & ~rst;
   assign regwrite   = rw_raw & ~rst;
   assign instr_done = done_raw & ~rst;
   assign pcen       = ~rst & (pcwrite | (branch & zero));
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output
// vectors are queued per instruction and compared each cycle.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] op = '0;
   logic [5:0] funct = '0;
   logic       zero = 1'b0;
   logic       iord, memwrite, irwrite, regdst, memtoreg;
   logic       regwrite, alusrca, pcen, instr_done;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluc;
   logic [3:0] state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [19:0] sbq[$];
   logic [19:0] obs;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .alusrca(alusrca), .pcen(pcen), .instr_done(instr_done),
      .alusrcb(alusrcb), .pcsrc(pcsrc), .aluc(aluc), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, iord, memwrite, irwrite, regdst, memtoreg,
                 regwrite, alusrca, pcen, instr_done,
                 alusrcb, pcsrc, aluc};

   localparam logic [19:0] RST_VEC = {4'd0, 9'b0, 2'b01, 2'b00, 3'b010};

   function automatic logic [2:0] exp_aluc(input logic [1:0] aop,
                                           input logic [5:0] f);
      if (aop == 2'b00) return 3'b010;
      if (aop == 2'b01) return 3'b110;
      if (aop == 2'b11) return 3'b011;
      if (f == 6'b100000) return 3'b010;
      if (f == 6'b100010) return 3'b110;
      if (f == 6'b100100) return 3'b000;
      if (f == 6'b100101) return 3'b001;
      if (f == 6'b101010) return 3'b111;
      return 3'b011;
   endfunction

   function automatic logic known_op(input logic [5:0] o);
      return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
             o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
   endfunction

   // singles order: iord memwrite irwrite regdst memtoreg regwrite alusrca pcen done
   function automatic logic [19:0] exp_vec(input logic [3:0] st,
                                           input logic [5:0] o,
                                           input logic [5:0] f,
                                           input logic z);
      logic [8:0] s;
      logic [1:0] b, p, aop;
      s = '0; b = 2'b00; p = 2'b00; aop = 2'b00;
      case (st)
         4'd0:  begin s = 9'b001000010; b = 2'b01; end
         4'd1:  begin s = {8'b0, ~known_op(o)}; b = 2'b11; end
         4'd2:  begin s = 9'b000000100; b = 2'b10; end
         4'd3:  s = 9'b100000000;
         4'd4:  s = 9'b000011001;
         4'd5:  s = 9'b110000001;
         4'd6:  begin s = 9'b000000100; aop = 2'b10; end
         4'd7:  s = 9'b000101001;
         4'd8:  begin s = {7'b0000001, z, 1'b1}; aop = 2'b01; p = 2'b01; end
         4'd9:  begin s = 9'b000000100; b = 2'b10; end
         4'd10: s = 9'b000001001;
         4'd11: begin s = 9'b000000011; p = 2'b10; end
         default: s = '0;
      endcase
      return {st, s, b, p, exp_aluc(aop, f)};
   endfunction

   task automatic push_instr(input logic [5:0] o, input logic [5:0] f,
                             input logic z);
      logic [19:0] sv;
      int len;
      case (o)
         6'b100011: begin sv = 20'h01234; len = 5; end
         6'b101011: begin sv = 20'h01250; len = 4; end
         6'b000000: begin sv = 20'h01670; len = 4; end
         6'b000100: begin sv = 20'h01800; len = 3; end
         6'b001000: begin sv = 20'h019A0; len = 4; end
         6'b000010: begin sv = 20'h01B00; len = 3; end
         default:   begin sv = 20'h01000; len = 2; end
      endcase
      for (int i = 0; i < len; i++)
         sbq.push_back(exp_vec(sv[19-4*i -: 4], o, f, z));
   endtask

   task automatic cmp_one(input string name);
      logic [19:0] e;
      #1;
      n_cmp++;
      if (sbq.size() == 0) begin
         n_bad++;
         $display("FAIL %s: scoreboard empty, got %h", name, obs);
      end else begin
         e = sbq.pop_front();
         if (obs !== e) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, obs, e, $time);
         end
      end
   endtask

   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic z, input string name);
      int n;
      op = o; funct = f; zero = z;
      push_instr(o, f, z);
      n = sbq.size();
      for (int i = 0; i < n; i++) begin
         cmp_one(name);
         @(negedge clk);
      end
      #1;
      n_cmp++;
      if (state !== 4'd0) begin
         n_bad++;
         $display("FAIL %s_ret_fetch: got state %0d want 0", name, state);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; op = 6'b100011; zero = 1'b1;
      @(negedge clk);
      sbq.push_back(RST_VEC);
      cmp_one("reset_hold");
      @(negedge clk);
      op = 6'b111111;
      sbq.push_back(RST_VEC);
      cmp_one("reset_hold2");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_lw();
      run_instr(6'b100011, 6'b000000, 1'b1, "lw");
   endtask

   task automatic test_rtype();
      logic [5:0] fl [6] = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b101010, 6'b000111};
      foreach (fl[i]) run_instr(6'b000000, fl[i], 1'b0, "rtype");
   endtask

   task automatic test_beq();
      run_instr(6'b000100, 6'b000000, 1'b1, "beq_taken");
      run_instr(6'b000100, 6'b101010, 1'b0, "beq_not_taken");
   endtask

   task automatic test_addi_j();
      run_instr(6'b001000, 6'b100010, 1'b1, "addi");
      run_instr(6'b000010, 6'b000000, 1'b1, "jump");
   endtask

   task automatic test_unknown();
      run_instr(6'b111111, 6'b000000, 1'b1, "unknown_op");
      run_instr(6'b000001, 6'b100000, 1'b0, "unknown_op2");
   endtask

   task automatic test_async_reset();
      op = 6'b101011; funct = '0; zero = 1'b0;
      push_instr(6'b101011, 6'b000000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cmp_one("sw_pre_abort");
         @(negedge clk);
      end
      cmp_one("sw_memwr");
      #1 rst = 1'b1;
      sbq.push_back(RST_VEC);
      cmp_one("async_reset");
      @(negedge clk);
      sbq.push_back(RST_VEC);
      cmp_one("async_reset_hold");
      @(negedge clk);
      rst = 1'b0;
      run_instr(6'b101011, 6'b000000, 1'b0, "sw_after_reset");
   endtask

   task automatic test_back_to_back();
      logic [5:0] ol [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b111111, 6'b010101};
      logic [5:0] fl [6] = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b101010, 6'b110011};
      for (int k = 0; k < 24; k++)
         run_instr(ol[$urandom_range(0, 7)], fl[$urandom_range(0, 5)],
                   1'($urandom_range(0, 1)), "b2b");
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype();
      test_beq();
      test_addi_j();
      test_unknown();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings are fixed by this document.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 op  in  6  opcode field, instr[31:26].
REQ-005 funct  in  6  function field, instr[5:0].
REQ-006 zero  in  1  ALU zero flag.
REQ-007 Single-bit outputs SHALL be, in this order: iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, instr_done.
REQ-008 alusrcb  out  2  ALU B select (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2).
REQ-009 pcsrc  out  2  PC select (00 ALU result, 01 ALUOut register, 10 jump target).
REQ-010 aluc  out  3  ALU operation code.
REQ-011 state  out  4  current FSM state, for debug.

Function
REQ-012 The FSM SHALL use this state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-013 Codes 12-15 SHALL transition to FETCH on the next edge with all outputs 0.
REQ-014 The FSM SHALL make these transitions:
- FETCH->DECODE.
- DECODE on op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH.
REQ-015 The FSM SHALL make these further transitions:
- MEMADR -> MEMRD if op=100011, else MEMWR.
- MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX -> FETCH.
REQ-016 Outputs other than pcen and aluc SHALL be Moore (a function of state only). Every output not listed for a state SHALL be 0.
REQ-017 The Moore outputs per state SHALL be:
- FETCH: irwrite=1, alusrcb=01, internal pcwrite=1.
- DECODE: alusrcb=11.
- MEMADR: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, internal branch=1.
- ADDIEX: alusrca=1, alusrcb=10.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, internal pcwrite=1.
REQ-018 The internal aluop SHALL default to 00.
REQ-019 pcen SHALL equal pcwrite OR (branch AND zero), combinationally from the current zero.
REQ-020 aluc SHALL be decoded combinationally:
- aluop=00 -> 010; aluop=01 -> 110.
- aluop=10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- aluop=10 with any other funct -> 011 (ALU result 0).
- aluop=11 -> 011.
REQ-021 instr_done SHALL be 1 for exactly one cycle in each terminal state (MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX, JEX) and in DECODE on an unrecognised op.
REQ-022 Latency SHALL be 5 cycles for lw, 4 for sw, R-type and addi, and 3 for beq and j, counted from FETCH to return to FETCH.

Reset
REQ-023 Asserting rst SHALL force state=FETCH immediately, without waiting for a clock edge.
REQ-024 While rst=1, pcen, irwrite, memwrite, regwrite and instr_done SHALL be 0; other outputs SHALL follow the FETCH values.
REQ-025 On the first rising edge after rst falls, FETCH SHALL be active, with the PC and IR updated, and the next state SHALL be DECODE.
REQ-026 Reset asserted mid-instruction SHALL abort it with no further write enables; the next instruction fetch starts cleanly.

Verification
REQ-027 lw (op=100011) from reset: state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; instr_done pulses in state 4.
REQ-028 R-type slt (op=000000, funct=101010): aluc=111 in RTYPEEX; regdst=1 and regwrite=1 in RTYPEWB; total 4 cycles.
REQ-029 beq in BEQEX with zero=1: pcen=1, pcsrc=01, aluc=110. With zero=0: pcen=0. Both cases return to FETCH next cycle.
REQ-030 Unknown op=111111: sequence FETCH, DECODE, FETCH; instr_done=1 in DECODE; no memwrite or regwrite asserted at any point.
REQ-031 rst asserted asynchronously in MEMWR between clock edges: state=0 and memwrite=0 before the next edge. After release, a sw (op=101011) completes in 4 cycles.
